load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I-style load/store unit in front of a single-ported word memory.
//   The memory reads combinationally and writes on the rising edge.
//   Sub-word stores are handled as a read-modify-write: read the old word,
//   merge the new lane in, then write the whole word back.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr            byte address (ADDR_WIDTH+2 bits)
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load result (0 for stores, 0 when idle)
//   resp_err            request rejected, no memory access took place
//   mem_*               word-memory interface (word address, enables, data)
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses are
//                         rejected with resp_err; otherwise the low address
//                         bits are ignored for those sizes.

module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Request fields captured at the accept edge
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Working registers
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  funct3_illegal;
  logic                  misaligned;
  logic                  reject;
  logic                  is_word_store;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_word;

  // Legal loads are 0,1,2,4,5; legal stores are 0,1,2.
  assign funct3_illegal = req_write ? (req_funct3 > 3'd2)
                                    : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  // Size is carried in funct3[1:0] for both loads and stores.
  assign misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`else
  assign misaligned = 1'b0;
`endif

  assign reject        = funct3_illegal || misaligned;
  assign accept        = req_valid && (state == IDLE);
  assign is_word_store = write_q && (funct3_q[1:0] == 2'd2);

  // Lane extraction for loads; funct3[2] selects zero extension.
  always_comb begin
    load_byte = 8'd0;
    case (addr_q[1:0])
      2'd0:    load_byte = mem_read_data[7:0];
      2'd1:    load_byte = mem_read_data[15:8];
      2'd2:    load_byte = mem_read_data[23:16];
      default: load_byte = mem_read_data[31:24];
    endcase
    load_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_data = mem_read_data;
    case (funct3_q[1:0])
      2'd0:    load_data = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
      2'd1:    load_data = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
      default: load_data = mem_read_data;
    endcase
  end

  // New word for SB/SH: old word with the addressed lane replaced.
  always_comb begin
    merge_word = mem_read_data;
    if (funct3_q[1:0] == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Rejected requests skip straight to RESP; word stores and loads finish
  // in ACCESS; sub-word stores need an extra MERGE cycle for the write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = reject ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q || is_word_store) begin
          state_next = RESP;
        end else begin
          state_next = MERGE;
        end
      end
      MERGE:   state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= reject;
      end else if (state == ACCESS) begin
        if (!write_q) begin
          rdata_q <= load_data;
        end else if (!is_word_store) begin
          merge_q <= merge_word;
        end
      end
    end
  end

  // Memory strobes come from the state (plus latched op type), so an
  // asynchronous reset drops them immediately and aborts any pending write.
  always_comb begin
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (state == ACCESS) begin
      mem_addr = addr_q[ADDR_WIDTH+1:2];
      if (is_word_store) begin
        mem_write_en   = 1'b1;
        mem_write_data = wdata_q;
      end else begin
        mem_read_en = 1'b1;
      end
    end else if (state == MERGE) begin
      mem_addr       = addr_q[ADDR_WIDTH+1:2];
      mem_write_en   = 1'b1;
      mem_write_data = merge_q;
    end
  end

  // req_ready is held low while reset is asserted even though the state is IDLE.
  assign req_ready  = (state == IDLE) && rst_n;
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : 1'b0;

endmodule
